serial_stream_deframer: RTL
===========================

SERIAL_STREAM_DEFRAMER -- requirements
Module: serial_stream_deframer

Interface
REQ-001 Parameter N, default 8: parallel word width and frame length in bits, N >= 2.
REQ-002 Parameter MSB_FIRST, default 0: 0 means the first serial bit lands in bit 0; 1 means it lands in bit N-1.
REQ-003 Reset rst, synchronous, active-high; clock clk.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 sin_data  in  1  serial data bit.
REQ-007 sin_valid  in  1  serial bit present this cycle.
REQ-008 sin_last  in  1  final bit of frame, qualified by sin_valid.
REQ-009 sin_ready  out  1  deframer accepts a bit this cycle.
REQ-010 par_data  out  N  assembled word, head of output FIFO.
REQ-011 par_valid  out  1  par_data holds a valid word.
REQ-012 par_ready  in  1  consumer accepts par_data.
REQ-013 frame_err  out  1  one-cycle pulse on a framing error.
REQ-014 err_cnt  out  8  saturating count of framing errors.

Function
REQ-015 A bit is accepted when sin_valid and sin_ready are both 1 in the same cycle; a word is popped when par_valid and par_ready are both 1.
REQ-016 FSM states:
  - IDLE: bit count 0.
  - SHIFT: 1 to N-1 bits held.
  - FLUSH: over-length frame, discarding bits.
REQ-017 FSM transitions:
  - IDLE to SHIFT: first accepted bit without sin_last.
  - SHIFT to IDLE: frame completes or a short-frame error occurs.
  - SHIFT to FLUSH: over-length error.
  - FLUSH to IDLE: an accepted bit with sin_last.
REQ-018 The bit counter is clogb2(N)+1 bits wide and resets to 0 on every return to IDLE.
REQ-019 Each accepted bit is written into the shift register at position cnt when MSB_FIRST=0, and at position N-1-cnt when MSB_FIRST=1.
REQ-020 Valid frame: exactly N accepted bits with sin_last on the Nth; the complete word is pushed into the output FIFO on the clock edge that accepts the Nth bit.
REQ-021 Latency: par_valid rises the cycle after the Nth bit is accepted when the FIFO was empty.
REQ-022 Short frame: sin_last on accepted bit k < N discards the partial word, pulses frame_err on the next cycle, increments err_cnt, and returns to IDLE.
REQ-023 Long frame: the Nth accepted bit without sin_last discards the word, pulses frame_err once, increments err_cnt, and enters FLUSH.
REQ-024 FLUSH accepts and drops bits until an accepted bit with sin_last, then returns to IDLE; further errors are not counted in FLUSH.
REQ-025 Single-bit frame: sin_last on the first bit is a short frame when N >= 2.
REQ-026 The output FIFO has depth 2 and delivers words in arrival order.
REQ-027 sin_ready = 0 exactly when the FIFO holds 2 words, independent of par_ready; it is 1 in all other cases, including in FLUSH.
REQ-028 Simultaneous push and pop with FIFO count 1 leaves the count at 1, presents the older word, and keeps the newer word as next.
REQ-029 par_data and par_valid stay stable while par_valid=1 and par_ready=0.
REQ-030 err_cnt saturates at 255 and never wraps.

Reset
REQ-031 Reset values:
  - FSM IDLE, bit count 0, shift register 0.
  - FIFO emptied, par_valid 0, par_data 0.
  - frame_err 0, err_cnt 0.
  - sin_ready 1 from the first cycle after reset.
REQ-032 Reset mid-frame or mid-FLUSH discards all partial and buffered words and raises no frame_err.

Structure
REQ-033 Shared package serial_link_pkg holds the FSM state constants, the default N, and the clogb2 function.
REQ-034 The output FIFO is a sub-module named sync_fifo2, parameterised by width, with push/pop/full/empty ports.

Verification
REQ-035 N=8, MSB_FIRST=0: send bits 1,0,1,0,0,1,0,1 with last on the 8th -> par_data=0xA5 and par_valid=1 on the cycle after the 8th bit; frame_err stays 0.
REQ-036 N=8, MSB_FIRST=1: send bits 1,0,0,0,0,0,0,0 with last on the 8th -> par_data=0x80.
REQ-037 N=8: send 5 bits with last on the 5th -> frame_err pulses once, err_cnt=1, par_valid stays 0; a following valid frame carrying 0x3C is delivered correctly.
REQ-038 N=8: send 11 bits with last on the 11th -> one frame_err at the 8th bit, err_cnt=1, no word output, FSM back in IDLE after the 11th bit.
REQ-039 N=8, par_ready=0: send frames 0x11, 0x22, 0x33 back-to-back:
  - sin_ready falls after 0x22 is pushed.
  - Raise par_ready: 0x11, 0x22, 0x33 are delivered in order.
  - Nothing is lost or duplicated.
REQ-040 N=8: assert rst after 4 bits with one word buffered -> par_valid=0 and err_cnt=0 the next cycle; a following frame carrying 0x5A is delivered as 0x5A.

Source files
------------

// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial link blocks: deframer FSM states,
// default word width and the ceil-log2 helper used to size counters.
package serial_link_pkg;

  localparam int DEFAULT_N = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  function automatic int clogb2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo2.sv
// Two-entry synchronous FIFO; head word is always presented on pop_data.
// Push while full and pop while empty are ignored.
module sync_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  assign full     = (count == 2'd2);
  assign empty    = (count == 2'd0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serial_stream_deframer.sv
// Collects N-bit serial frames into parallel words buffered in a 2-deep FIFO;
// short and over-length frames are dropped and counted as framing errors.
module serial_stream_deframer
  import serial_link_pkg::*;
#(
  parameter int N         = DEFAULT_N,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sin_data,
  input  logic         sin_valid,
  input  logic         sin_last,
  output logic         sin_ready,
  output logic [N-1:0] par_data,
  output logic         par_valid,
  input  logic         par_ready,
  output logic         frame_err,
  output logic [7:0]   err_cnt,
  output state_t       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; valid never waits for ready, and sin_ready depends only on FIFO
  // occupancy so it never combinationally depends on sin_valid or par_ready.

  localparam int CW = clogb2(N) + 1;
  localparam int IW = clogb2(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [N-1:0]   shreg, shreg_nxt, shreg_ins;
  logic [IW-1:0]  pos;
  logic           accept;
  logic           push;
  logic           err_evt;
  logic           fifo_full;
  logic           fifo_empty;

  assign sin_ready = !fifo_full;
  assign accept    = sin_valid && sin_ready;
  assign par_valid = !fifo_empty;
  assign dbg_state = state;
  assign pos       = MSB_FIRST ? IW'(LAST_IDX - cnt) : IW'(cnt);

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    shreg_nxt      = shreg;
    shreg_ins      = shreg;
    shreg_ins[pos] = sin_data;
    push           = 1'b0;
    err_evt        = 1'b0;
    if (accept) begin
      case (state)
        ST_IDLE: begin
          // N >= 2, so a frame ending on its first bit is always short.
          if (sin_last) begin
            err_evt = 1'b1;
          end else begin
            shreg_nxt = shreg_ins;
            cnt_nxt   = CW'(1);
            state_nxt = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cnt == LAST_IDX) begin
            cnt_nxt = '0;
            if (sin_last) begin
              push      = 1'b1;
              state_nxt = ST_IDLE;
            end else begin
              err_evt   = 1'b1;
              state_nxt = ST_FLUSH;
            end
          end else if (sin_last) begin
            err_evt   = 1'b1;
            cnt_nxt   = '0;
            state_nxt = ST_IDLE;
          end else begin
            shreg_nxt = shreg_ins;
            cnt_nxt   = cnt + CW'(1);
          end
        end
        ST_FLUSH: begin
          if (sin_last) state_nxt = ST_IDLE;
        end
        default: begin
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
      err_cnt   <= 8'd0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      shreg     <= shreg_nxt;
      frame_err <= err_evt;
      if (err_evt && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  // The completed word includes the bit accepted on this edge.
  sync_fifo2 #(.W(N)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shreg_ins),
    .pop       (par_ready),
    .pop_data  (par_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
